// File: rtl/zap_wb_merger_if.sv
// Signal bundle between the two cache wishbone masters, the merger and the external bus.
// The merger uses the slave view; the cache/bus side uses the master view.
interface zap_wb_merger_if;
  logic        i_c_wb_stb;
  logic        i_c_wb_cyc;
  logic        i_c_wb_wen;
  logic [3:0]  i_c_wb_sel;
  logic [31:0] i_c_wb_dat;
  logic [31:0] i_c_wb_adr;
  logic [2:0]  i_c_wb_cti;

  logic        i_d_wb_stb;
  logic        i_d_wb_cyc;
  logic        i_d_wb_wen;
  logic [3:0]  i_d_wb_sel;
  logic [31:0] i_d_wb_dat;
  logic [31:0] i_d_wb_adr;
  logic [2:0]  i_d_wb_cti;

  logic        o_c_wb_ack;
  logic        o_c_wb_err;
  logic        o_d_wb_ack;
  logic        o_d_wb_err;

  logic        o_wb_stb;
  logic        o_wb_cyc;
  logic        o_wb_wen;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic [31:0] o_wb_adr;
  logic [2:0]  o_wb_cti;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport slave (
    input  i_c_wb_stb, i_c_wb_cyc, i_c_wb_wen, i_c_wb_sel, i_c_wb_dat, i_c_wb_adr, i_c_wb_cti,
    input  i_d_wb_stb, i_d_wb_cyc, i_d_wb_wen, i_d_wb_sel, i_d_wb_dat, i_d_wb_adr, i_d_wb_cti,
    input  i_wb_ack, i_wb_err,
    output o_c_wb_ack, o_c_wb_err, o_d_wb_ack, o_d_wb_err,
    output o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
  );

  modport master (
    output i_c_wb_stb, i_c_wb_cyc, i_c_wb_wen, i_c_wb_sel, i_c_wb_dat, i_c_wb_adr, i_c_wb_cti,
    output i_d_wb_stb, i_d_wb_cyc, i_d_wb_wen, i_d_wb_sel, i_d_wb_dat, i_d_wb_adr, i_d_wb_cti,
    output i_wb_ack, i_wb_err,
    input  o_c_wb_ack, o_c_wb_err, o_d_wb_ack, o_d_wb_err,
    input  o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
  );
endinterface

// File: rtl/zap_wb_merger.sv
// Two-master wishbone merger: round-robin grant held across bursts, registered
// external request, combinational ACK/ERR routing back to the granted cache.
//
// state | meaning
// CODE  | instruction cache owns the external bus
// DATA  | data cache owns the external bus
module zap_wb_merger (
  input logic           i_clk,
  input logic           i_reset,
  zap_wb_merger_if.slave bus
);
  localparam logic [2:0] CTI_BURST = 3'b010;
  localparam logic [2:0] CTI_EOB   = 3'b111;

  typedef enum logic {CODE = 1'b0, DATA = 1'b1} master_t;

  master_t sel_ff, sel_nxt;
  master_t last_ff, last_nxt;
  logic    sw;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_ff  <= CODE;
      last_ff <= DATA;
    end else begin
      sel_ff  <= sel_nxt;
      last_ff <= last_nxt;
    end
  end

  // Grant may only move once a classic cycle or the EOB beat has been acked.
  always_comb begin
    sw       = !bus.o_wb_stb || (bus.i_wb_ack && (bus.o_wb_cti != CTI_BURST));
    sel_nxt  = sel_ff;
    last_nxt = last_ff;
    if (sw) begin
      unique case ({bus.i_c_wb_cyc, bus.i_d_wb_cyc})
        2'b10:   sel_nxt = CODE;
        2'b01:   sel_nxt = DATA;
        2'b11: begin
          sel_nxt  = (last_ff == CODE) ? DATA : CODE;
          last_nxt = sel_nxt;
        end
        default: sel_nxt = sel_ff;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_wb_stb <= 1'b0;
      bus.o_wb_cyc <= 1'b0;
      bus.o_wb_wen <= 1'b0;
      bus.o_wb_sel <= 4'h0;
      bus.o_wb_dat <= 32'h0;
      bus.o_wb_adr <= 32'h0;
      bus.o_wb_cti <= CTI_EOB;
    end else if (sel_nxt == CODE) begin
      bus.o_wb_stb <= bus.i_c_wb_stb;
      bus.o_wb_cyc <= bus.i_c_wb_cyc;
      bus.o_wb_wen <= bus.i_c_wb_wen;
      bus.o_wb_sel <= bus.i_c_wb_sel;
      bus.o_wb_dat <= bus.i_c_wb_dat;
      bus.o_wb_adr <= bus.i_c_wb_adr;
      bus.o_wb_cti <= bus.i_c_wb_cti;
    end else begin
      bus.o_wb_stb <= bus.i_d_wb_stb;
      bus.o_wb_cyc <= bus.i_d_wb_cyc;
      bus.o_wb_wen <= bus.i_d_wb_wen;
      bus.o_wb_sel <= bus.i_d_wb_sel;
      bus.o_wb_dat <= bus.i_d_wb_dat;
      bus.o_wb_adr <= bus.i_d_wb_adr;
      bus.o_wb_cti <= bus.i_d_wb_cti;
    end
  end

  // Responses are suppressed during reset so a dying burst cannot ack a cache.
  assign bus.o_c_wb_ack = bus.i_wb_ack && (sel_ff == CODE) && !i_reset;
  assign bus.o_c_wb_err = bus.i_wb_err && (sel_ff == CODE) && !i_reset;
  assign bus.o_d_wb_ack = bus.i_wb_ack && (sel_ff == DATA) && !i_reset;
  assign bus.o_d_wb_err = bus.i_wb_err && (sel_ff == DATA) && !i_reset;

  err_needs_ack: assert property (@(posedge i_clk) disable iff (i_reset)
                                  !(bus.i_wb_err && !bus.i_wb_ack))
    else $fatal(1, "zap_wb_merger: slave raised ERR without ACK");
endmodule

// File: tb/tb_zap_wb_merger.sv
// Bench for zap_wb_merger: classic-cycle vector table plus burst, round-robin,
// reset and idle sequences, with a grant-order scoreboard checked on every ACK.
module tb_zap_wb_merger;
  localparam logic [2:0] CLS = 3'b000;
  localparam logic [2:0] BST = 3'b010;
  localparam logic [2:0] EOB = 3'b111;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  zap_wb_merger_if bus();
  zap_wb_merger dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct { bit m; logic [31:0] adr; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    bit m; bit wen; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat; bit err;
    bit c_ack; bit c_err; bit d_ack; bit d_err;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_m(input bit m, input bit cyc, input logic [31:0] adr, input logic [2:0] cti,
                       input bit wen, input logic [3:0] sel, input logic [31:0] dat);
    if (!m) begin
      bus.i_c_wb_cyc = cyc; bus.i_c_wb_stb = cyc; bus.i_c_wb_adr = adr; bus.i_c_wb_cti = cti;
      bus.i_c_wb_wen = wen; bus.i_c_wb_sel = sel; bus.i_c_wb_dat = dat;
    end else begin
      bus.i_d_wb_cyc = cyc; bus.i_d_wb_stb = cyc; bus.i_d_wb_adr = adr; bus.i_d_wb_cti = cti;
      bus.i_d_wb_wen = wen; bus.i_d_wb_sel = sel; bus.i_d_wb_dat = dat;
    end
  endtask

  task automatic ack_beat(input bit err);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_err = err;
    @(negedge i_clk);
    tick();
    bus.i_wb_ack = 1'b0;
    bus.i_wb_err = 1'b0;
  endtask

  // Every acked beat must carry the address and go to the master the arbiter should have picked.
  always @(negedge i_clk) begin
    if (!i_reset && bus.o_wb_stb && bus.i_wb_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack adr=%h", bus.o_wb_adr);
      end else begin
        mon_e = sb.pop_front();
        if (bus.o_wb_adr !== mon_e.adr || bus.o_c_wb_ack !== !mon_e.m || bus.o_d_wb_ack !== mon_e.m) begin
          errors++;
          $display("FAIL sb_beat got adr=%h c_ack=%b d_ack=%b want adr=%h master=%0d",
                   bus.o_wb_adr, bus.o_c_wb_ack, bus.o_d_wb_ack, mon_e.adr, mon_e.m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0204, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0208, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b0, 4'h1, 32'h0000_010C, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 4'hC, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    set_m(0, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    set_m(1, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_err = 1'b1;

    // reset: responses blocked, bus at reset values
    @(negedge i_clk);
    chk("rst_c_ack", bus.o_c_wb_ack, 0);
    chk("rst_d_err", bus.o_d_wb_err, 0);
    tick();
    @(negedge i_clk);
    chk("rst_acks", {bus.o_c_wb_ack, bus.o_c_wb_err, bus.o_d_wb_ack, bus.o_d_wb_err}, 4'b0000);
    chk("rst_ctl", {bus.o_wb_stb, bus.o_wb_cyc, bus.o_wb_wen}, 3'b000);
    chk("rst_cti", bus.o_wb_cti, EOB);
    chk("rst_sel", bus.o_wb_sel, 4'h0);
    chk("rst_adr", bus.o_wb_adr, 32'h0);
    chk("rst_dat", bus.o_wb_dat, 32'h0);
    tick();
    bus.i_wb_ack = 1'b0;
    bus.i_wb_err = 1'b0;
    i_reset = 1'b0;
    tick();

    // classic-cycle vector table
    for (int i = 0; i < 5; i++) begin
      set_m(vt[i].m, 1, vt[i].adr, CLS, vt[i].wen, vt[i].sel, vt[i].dat);
      sb.push_back('{vt[i].m, vt[i].adr});
      tick();
      chk($sformatf("vec%0d_ctl", i), {bus.o_wb_stb, bus.o_wb_cyc, bus.o_wb_wen}, {2'b11, vt[i].wen});
      chk($sformatf("vec%0d_adr", i), bus.o_wb_adr, vt[i].adr);
      chk($sformatf("vec%0d_dat_sel_cti", i), {bus.o_wb_dat[27:0], bus.o_wb_sel, bus.o_wb_cti[0]},
          {vt[i].dat[27:0], vt[i].sel, 1'b0});
      set_m(vt[i].m, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
      bus.i_wb_ack = 1'b1;
      bus.i_wb_err = vt[i].err;
      @(negedge i_clk);
      chk($sformatf("vec%0d_resp", i),
          {bus.o_c_wb_ack, bus.o_c_wb_err, bus.o_d_wb_ack, bus.o_d_wb_err},
          {vt[i].c_ack, vt[i].c_err, vt[i].d_ack, vt[i].d_err});
      tick();
      bus.i_wb_ack = 1'b0;
      bus.i_wb_err = 1'b0;
    end

    // burst hold: data burst, code requests during beat 2 with a wait state
    set_m(1, 1, 32'h2000, BST, 0, 4'hF, 32'h0);
    sb.push_back('{1'b1, 32'h2000});
    tick();
    chk("bst_b0_adr", bus.o_wb_adr, 32'h2000);
    set_m(1, 1, 32'h2004, BST, 0, 4'hF, 32'h0);
    sb.push_back('{1'b1, 32'h2004});
    ack_beat(0);
    set_m(0, 1, 32'h00C0, CLS, 0, 4'hF, 32'h0);
    tick();
    chk("bst_ws_adr", bus.o_wb_adr, 32'h2004);
    chk("bst_ws_cti", bus.o_wb_cti, BST);
    set_m(1, 1, 32'h2008, BST, 0, 4'hF, 32'h0);
    sb.push_back('{1'b1, 32'h2008});
    ack_beat(0);
    chk("bst_b2_adr", bus.o_wb_adr, 32'h2008);
    set_m(1, 1, 32'h200C, EOB, 0, 4'hF, 32'h0);
    sb.push_back('{1'b1, 32'h200C});
    ack_beat(0);
    chk("bst_eob_adr", bus.o_wb_adr, 32'h200C);
    chk("bst_eob_cti", bus.o_wb_cti, EOB);
    set_m(1, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    sb.push_back('{1'b0, 32'h00C0});
    ack_beat(0);
    chk("bst_then_code_adr", bus.o_wb_adr, 32'h00C0);
    set_m(0, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    ack_beat(0);

    // idle hold after a data transfer: grant parks on DATA
    set_m(1, 1, 32'h0600, CLS, 0, 4'hF, 32'h0);
    sb.push_back('{1'b1, 32'h0600});
    tick();
    set_m(1, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    ack_beat(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d_stb", i), bus.o_wb_stb, 0);
    end
    bus.i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("idle_grant_data", {bus.o_c_wb_ack, bus.o_d_wb_ack}, 2'b01);
    tick();
    bus.i_wb_ack = 1'b0;

    // round robin from reset release with both masters requesting
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    set_m(0, 1, 32'h0300, CLS, 0, 4'hF, 32'h0);
    set_m(1, 1, 32'h0400, CLS, 0, 4'hF, 32'h0);
    sb.push_back('{1'b0, 32'h0300});
    sb.push_back('{1'b1, 32'h0400});
    sb.push_back('{1'b0, 32'h0304});
    sb.push_back('{1'b1, 32'h0404});
    sb.push_back('{1'b0, 32'h0308});
    tick();
    chk("rr_first_code", bus.o_wb_adr, 32'h0300);
    set_m(0, 1, 32'h0304, CLS, 0, 4'hF, 32'h0);
    ack_beat(0);
    chk("rr_second_data", bus.o_wb_adr, 32'h0400);
    set_m(1, 1, 32'h0404, CLS, 0, 4'hF, 32'h0);
    ack_beat(0);
    chk("rr_third_code", bus.o_wb_adr, 32'h0304);
    set_m(0, 1, 32'h0308, CLS, 0, 4'hF, 32'h0);
    ack_beat(0);
    chk("rr_fourth_data", bus.o_wb_adr, 32'h0404);
    set_m(1, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    ack_beat(0);
    set_m(0, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    ack_beat(0);

    // reset at beat 2 of a code burst
    set_m(0, 1, 32'h0500, BST, 0, 4'hF, 32'h0);
    sb.push_back('{1'b0, 32'h0500});
    tick();
    set_m(0, 1, 32'h0504, BST, 0, 4'hF, 32'h0);
    sb.push_back('{1'b0, 32'h0504});
    ack_beat(0);
    chk("rstb_b1_adr", bus.o_wb_adr, 32'h0504);
    i_reset = 1'b1;
    bus.i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("rstb_acks", {bus.o_c_wb_ack, bus.o_d_wb_ack}, 2'b00);
    tick();
    chk("rstb_ctl", {bus.o_wb_stb, bus.o_wb_cyc}, 2'b00);
    chk("rstb_cti", bus.o_wb_cti, EOB);
    chk("rstb_pending", sb.size(), 1);
    sb.delete();
    bus.i_wb_ack = 1'b0;
    i_reset = 1'b0;
    set_m(0, 0, 32'h0, CLS, 0, 4'h0, 32'h0);
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
